// File: rtl/reg_file_2r1w_pkg.sv
// Shared core constants and types for the integer register file.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : core_pkg

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: two read ports, one write port, one debug read port.
interface reg_file_2r1w_if;
  import core_pkg::*;

  reg_addr_t a1;
  reg_addr_t a2;
  reg_addr_t a3;
  logic      we3;
  word_t     wd3;
  word_t     rd1;
  word_t     rd2;
  reg_addr_t dbg_addr;
  word_t     dbg_data;

  modport master (
    output a1, a2, a3, we3, wd3, dbg_addr,
    input  rd1, rd2, dbg_data
  );

  modport slave (
    input  a1, a2, a3, we3, wd3, dbg_addr,
    output rd1, rd2, dbg_data
  );

endinterface : reg_file_2r1w_if

// File: rtl/reg_file_2r1w_decoder_5_32.sv
// 5-to-32 one-hot decoder for the register-file write address.
module decoder_5_32
  import core_pkg::*;
(
  input  reg_addr_t        addr,
  output logic [NREGS-1:0] onehot
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule : decoder_5_32

// File: rtl/reg_file_2r1w.sv
// 32-entry RV integer register file, 2 combinational reads + 1 synchronous write.
// Optional macro REGFILE_BYPASS_EN adds write-through bypass on rd1/rd2.
module reg_file_2r1w
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t a1,
  input  reg_addr_t a2,
  input  reg_addr_t a3,
  input  logic      we3,
  input  word_t     wd3,
  output word_t     rd1,
  output word_t     rd2,
  input  reg_addr_t dbg_addr,
  output word_t     dbg_data
);

  logic [NREGS-1:0] wsel;
  logic             wr_ok;
  word_t            regs_q [NREGS-1:1];
  word_t            regs_d [NREGS-1:1];
  word_t            rd1_st;
  word_t            rd2_st;

  decoder_5_32 u_wdec (
    .addr   (a3),
    .onehot (wsel)
  );

  // x0 has no storage, so a write decoding to slot 0 is simply dropped here.
  assign wr_ok = we3 & ~rst & ~wsel[0];

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && wsel[i]) begin
        regs_d[i] = wd3;
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  // NOTE: the array is cleared on reset because software may read any register before writing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd1_st   = '0;
    rd2_st   = '0;
    dbg_data = '0;
    if (a1 != REG_ZERO)       rd1_st   = regs_q[a1];
    if (a2 != REG_ZERO)       rd2_st   = regs_q[a2];
    if (dbg_addr != REG_ZERO) dbg_data = regs_q[dbg_addr];
  end

`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes x0 and reset, so the bypass inherits both guards.
  assign rd1 = (wr_ok && (a1 == a3)) ? wd3 : rd1_st;
  assign rd2 = (wr_ok && (a2 == a3)) ? wd3 : rd2_st;
`else
  assign rd1 = rd1_st;
  assign rd2 = rd2_st;
`endif

endmodule : reg_file_2r1w
